// File: rtl/ad9363_pkg.sv
// Shared types and sizes for the AD9363 IDELAY calibration sequencer.
package ad9363_pkg;

  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 32;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_WAIT,
    S_NEXT,
    S_FINAL,
    S_DONE
  } cal_state_e;

endpackage

// File: rtl/ad9363_win_track.sv
// Longest-passing-window tracker: fed one tap verdict per sweep step, it keeps
// the first longest contiguous run of passing taps and presents its centre.
module ad9363_win_track
  import ad9363_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic             i_pass,
  input  logic [TAP_W-1:0] i_tap,
  output logic             o_found,
  output logic [TAP_W-1:0] o_center
);

  logic [TAP_W-1:0] r_cur_start;
  logic [TAP_W:0]   r_cur_len;
  logic [TAP_W-1:0] r_best_start;
  logic [TAP_W:0]   r_best_len;

  logic [TAP_W-1:0] w_run_start;
  logic [TAP_W:0]   w_run_len;
  logic [TAP_W-1:0] w_half;

  assign w_run_start = (r_cur_len == '0) ? i_tap : r_cur_start;
  assign w_run_len   = r_cur_len + 1'b1;

  // Extend or break the current run; promote it only when strictly longer so
  // the earliest of equal-length windows is kept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (i_clear) begin
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (i_valid) begin
      if (i_pass) begin
        r_cur_start <= w_run_start;
        r_cur_len   <= w_run_len;
        if (w_run_len > r_best_len) begin
          r_best_start <= w_run_start;
          r_best_len   <= w_run_len;
        end
      end else begin
        r_cur_len <= '0;
      end
    end
  end

  // Windows never wrap, so start + floor((len-1)/2) always stays within 0..31.
  assign w_half   = TAP_W'((r_best_len - 1'b1) >> 1);
  assign o_found  = (r_best_len != '0);
  assign o_center = r_best_start + w_half;

endmodule

// File: rtl/ad9363_delay_cal.sv
// IDELAY tap-sweep calibration for one AD9363 CMOS interface channel.
// Sweeps taps 0..31, scores each with the external pattern checker, then loads
// the centre of the longest passing window (DEFAULT_TAP if nothing passed).
// Optional build macro AD9363_DELAY_CAL_MANUAL_EN adds a manual tap-load port
// usable while the sequencer is idle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for cal_start (or a manual load, when built in)
// S_LOAD   | drive current tap to the IDELAY with a one-cycle load strobe
// S_SETTLE | let the delay line settle for SETTLE_CYCLES
// S_CHECK  | one-cycle chk_start to the pattern checker
// S_WAIT   | wait for chk_done, or score as fail after TIMEOUT_CYCLES
// S_NEXT   | fold the verdict into the window tracker, advance the tap
// S_FINAL  | load the chosen tap and latch the result flags
// S_DONE   | result held; behaves like S_IDLE
module ad9363_delay_cal
  import ad9363_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned DEFAULT_TAP    = 16
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_cal_start,
  input  logic                i_chk_done,
  input  logic                i_chk_pass,
`ifdef AD9363_DELAY_CAL_MANUAL_EN
  input  logic                i_man_load,
  input  logic [TAP_W-1:0]    i_man_tap,
`endif
  output logic                o_chk_start,
  output logic [TAP_W-1:0]    o_delay_value,
  output logic                o_delay_load_en,
  output logic                o_cal_busy,
  output logic                o_cal_done,
  output logic                o_cal_fail,
  output logic [TAP_W-1:0]    o_cal_tap,
  output logic [NUM_TAPS-1:0] o_pass_map
);

  localparam logic [TAP_W-1:0] DEF_TAP   = TAP_W'(DEFAULT_TAP);
  localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYCLES - 1);

  cal_state_e          r_state;
  cal_state_e          w_state_next;
  logic [TAP_W-1:0]    r_tap;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_TAPS-1:0] r_pass_map;
  logic [TAP_W-1:0]    r_delay_value;
  logic                r_load_en;
  logic                r_cal_busy;
  logic                r_cal_done;
  logic                r_cal_fail;
  logic [TAP_W-1:0]    r_cal_tap;

  logic                w_chk_start;
  logic                w_start_ok;
  logic                w_trk_valid;
  logic                w_cnt_tc;
  logic                w_found;
  logic [TAP_W-1:0]    w_center;
  logic [TAP_W-1:0]    w_final_tap;

  assign w_cnt_tc    = (r_cnt == '0);
  assign w_final_tap = w_found ? w_center : DEF_TAP;

  // State register.
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and the combinational checker strobe.
  always_comb begin
    w_state_next = r_state;
    w_chk_start  = 1'b0;
    w_start_ok   = 1'b0;
    w_trk_valid  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_cal_start) begin
          w_start_ok   = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD:   w_state_next = S_SETTLE;
      S_SETTLE: if (w_cnt_tc) w_state_next = S_CHECK;
      S_CHECK: begin
        w_chk_start  = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT:   if (i_chk_done || w_cnt_tc) w_state_next = S_NEXT;
      S_NEXT: begin
        w_trk_valid  = 1'b1;
        w_state_next = (r_tap == LAST_TAP) ? S_FINAL : S_LOAD;
      end
      S_FINAL:  w_state_next = S_DONE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Sweep datapath: tap index, shared settle/timeout down-counter, results.
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tap         <= '0;
      r_cnt         <= '0;
      r_pass_map    <= '0;
      r_delay_value <= DEF_TAP;
      r_load_en     <= 1'b0;
      r_cal_busy    <= 1'b0;
      r_cal_done    <= 1'b0;
      r_cal_fail    <= 1'b0;
      r_cal_tap     <= DEF_TAP;
    end else begin
      r_load_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_tap      <= '0;
            r_pass_map <= '0;
            r_cal_done <= 1'b0;
            r_cal_fail <= 1'b0;
            r_cal_busy <= 1'b1;
          end
`ifdef AD9363_DELAY_CAL_MANUAL_EN
          else if (i_man_load) begin
            r_delay_value <= i_man_tap;
            r_cal_tap     <= i_man_tap;
            r_load_en     <= 1'b1;
          end
`endif
        end
        S_LOAD: begin
          r_delay_value <= r_tap;
          r_load_en     <= 1'b1;
          r_cnt         <= SETTLE_LD;
        end
        S_SETTLE: if (!w_cnt_tc) r_cnt <= r_cnt - 1'b1;
        S_CHECK:  r_cnt <= TMO_LD;
        S_WAIT: begin
          if (i_chk_done)     r_pass_map[r_tap] <= i_chk_pass;
          else if (w_cnt_tc)  r_pass_map[r_tap] <= 1'b0;
          else                r_cnt <= r_cnt - 1'b1;
        end
        S_NEXT: if (r_tap != LAST_TAP) r_tap <= r_tap + 1'b1;
        S_FINAL: begin
          r_delay_value <= w_final_tap;
          r_cal_tap     <= w_final_tap;
          r_load_en     <= 1'b1;
          r_cal_fail    <= ~w_found;
          r_cal_done    <= 1'b1;
          r_cal_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  ad9363_win_track u_win_track (
    .i_clk    (i_ref_clk),
    .i_rst    (i_rst),
    .i_clear  (w_start_ok),
    .i_valid  (w_trk_valid),
    .i_pass   (r_pass_map[r_tap]),
    .i_tap    (r_tap),
    .o_found  (w_found),
    .o_center (w_center)
  );

  assign o_chk_start     = w_chk_start;
  assign o_delay_value   = r_delay_value;
  assign o_delay_load_en = r_load_en;
  assign o_cal_busy      = r_cal_busy;
  assign o_cal_done      = r_cal_done;
  assign o_cal_fail      = r_cal_fail;
  assign o_cal_tap       = r_cal_tap;
  assign o_pass_map      = r_pass_map;

endmodule

// File: tb/tb_ad9363_delay_cal.sv
// Directed bench for ad9363_delay_cal with a mask-driven pattern-checker model.
module tb_ad9363_delay_cal;

  logic        ref_clk = 1'b0;
  logic        rst;
  logic        cal_start;
  logic        chk_done;
  logic        chk_pass;
  logic        chk_start;
  logic [4:0]  delay_value;
  logic        delay_load_en;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;
  logic [4:0]  cal_tap;
  logic [31:0] pass_map;
`ifdef AD9363_DELAY_CAL_MANUAL_EN
  logic        man_load = 1'b0;
  logic [4:0]  man_tap  = 5'd0;
`endif

  logic [31:0] pass_mask = 32'h0;
  logic        rsp_en    = 1'b1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned mon_cyc      = 0;
  int unsigned mon_last_cyc = 0;
  int unsigned mon_gap      = 0;
  int unsigned mon_cnt      = 0;
  logic [4:0]  mon_last_val = 5'd0;

  ad9363_delay_cal #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (8),
    .DEFAULT_TAP    (16)
  ) dut (
    .i_ref_clk       (ref_clk),
    .i_rst           (rst),
    .i_cal_start     (cal_start),
    .i_chk_done      (chk_done),
    .i_chk_pass      (chk_pass),
`ifdef AD9363_DELAY_CAL_MANUAL_EN
    .i_man_load      (man_load),
    .i_man_tap       (man_tap),
`endif
    .o_chk_start     (chk_start),
    .o_delay_value   (delay_value),
    .o_delay_load_en (delay_load_en),
    .o_cal_busy      (cal_busy),
    .o_cal_done      (cal_done),
    .o_cal_fail      (cal_fail),
    .o_cal_tap       (cal_tap),
    .o_pass_map      (pass_map)
  );

  always #5 ref_clk = ~ref_clk;

  // Load-strobe monitor: pulse count, spacing and last value loaded.
  always @(posedge ref_clk) begin
    mon_cyc <= mon_cyc + 1;
    if (delay_load_en) begin
      mon_cnt      <= mon_cnt + 1;
      mon_gap      <= mon_cyc - mon_last_cyc;
      mon_last_cyc <= mon_cyc;
      mon_last_val <= delay_value;
    end
  end

  // Checker model: answers two cycles after chk_start using pass_mask.
  initial begin : checker_model
    logic [4:0] rsp_tap;
    chk_done = 1'b0;
    chk_pass = 1'b0;
    forever begin
      @(negedge ref_clk);
      chk_done = 1'b0;
      if (chk_start && rsp_en) begin
        rsp_tap = delay_value;
        @(negedge ref_clk);
        @(negedge ref_clk);
        chk_done = 1'b1;
        chk_pass = pass_mask[rsp_tap];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge ref_clk);
    cal_start = 1'b1;
    @(negedge ref_clk);
    cal_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!cal_done && n < 3000) begin
      @(negedge ref_clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(cal_done), 32'd1);
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_delay_value"}, 32'(delay_value), 32'd16);
    check_eq({tag, "_cal_tap"},     32'(cal_tap),     32'd16);
    check_eq({tag, "_load_en"},     32'(delay_load_en), 32'd0);
    check_eq({tag, "_chk_start"},   32'(chk_start),   32'd0);
    check_eq({tag, "_busy"},        32'(cal_busy),    32'd0);
    check_eq({tag, "_done"},        32'(cal_done),    32'd0);
    check_eq({tag, "_fail"},        32'(cal_fail),    32'd0);
    check_eq({tag, "_pass_map"},    pass_map,         32'd0);
  endtask

  // Full sweep with the given mask; checks result registers and load strobes.
  task automatic run_cal(input string tag, input logic [31:0] mask, input logic rsp,
                         input logic [4:0] exp_tap, input logic exp_fail,
                         input int unsigned exp_gap, input logic mid_start);
    int unsigned base;
    pass_mask = mask;
    rsp_en    = rsp;
    base      = mon_cnt;
    pulse_start();
    check_eq({tag, "_busy_rise"}, 32'(cal_busy), 32'd1);
    check_eq({tag, "_done_clr"},  32'(cal_done), 32'd0);
    if (mid_start) begin
      repeat (40) @(negedge ref_clk);
      cal_start = 1'b1;
      @(negedge ref_clk);
      cal_start = 1'b0;
      repeat (120) @(negedge ref_clk);
      cal_start = 1'b1;
      @(negedge ref_clk);
      cal_start = 1'b0;
    end
    wait_done(tag);
    check_eq({tag, "_pass_map"},  pass_map,             rsp ? mask : 32'd0);
    check_eq({tag, "_cal_tap"},   32'(cal_tap),         32'(exp_tap));
    check_eq({tag, "_delay_val"}, 32'(delay_value),     32'(exp_tap));
    check_eq({tag, "_final_ld"},  32'(mon_last_val),    32'(exp_tap));
    check_eq({tag, "_fail"},      32'(cal_fail),        32'(exp_fail));
    check_eq({tag, "_busy_end"},  32'(cal_busy),        32'd0);
    check_eq({tag, "_n_loads"},   mon_cnt - base,       32'd33);
    check_eq({tag, "_tap_gap"},   mon_gap,              exp_gap);
  endtask

  initial begin : main
    int unsigned base;
    int unsigned cnt_at_rst;
    int          n;
    rst       = 1'b1;
    cal_start = 1'b0;
    repeat (3) @(negedge ref_clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge ref_clk);

    // Per-tap time with a responding checker: 1 + 4 + 1 + 2 + 1 = 9 cycles.
    run_cal("win8_20",   32'h001FFF00, 1'b1, 5'd14, 1'b0, 9,  1'b0);
    run_cal("two_win",   32'h00001C3C, 1'b1, 5'd3,  1'b0, 9,  1'b0);
    run_cal("eq_win",    32'h00F0000F, 1'b1, 5'd1,  1'b0, 9,  1'b0);
    run_cal("all_pass",  32'hFFFFFFFF, 1'b1, 5'd15, 1'b0, 9,  1'b0);
    run_cal("single31",  32'h80000000, 1'b1, 5'd31, 1'b0, 9,  1'b0);
    // Silent checker: WAIT lasts the full 8 cycles, per tap 1 + 4 + 1 + 8 + 1.
    run_cal("timeout",   32'hFFFFFFFF, 1'b0, 5'd16, 1'b1, 15, 1'b0);
    run_cal("mid_start", 32'h001FFF00, 1'b1, 5'd14, 1'b0, 9,  1'b1);

    // Reset right after tap 10 is loaded, then recalibrate from scratch.
    pass_mask = 32'h001FFF00;
    rsp_en    = 1'b1;
    base      = mon_cnt;
    pulse_start();
    n = 0;
    while (!(mon_cnt != base && mon_last_val == 5'd10) && n < 1000) begin
      @(negedge ref_clk);
      n++;
    end
    check_eq("rst_tap10_seen", 32'(mon_last_val), 32'd10);
    #1 rst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    cnt_at_rst = mon_cnt;
    repeat (4) @(negedge ref_clk);
    rst = 1'b0;
    repeat (30) @(negedge ref_clk);
    check_eq("rst_no_final_ld", mon_cnt - cnt_at_rst, 32'd0);
    check_eq("rst_idle_busy",   32'(cal_busy),        32'd0);
    base = mon_cnt;
    pulse_start();
    n = 0;
    while (mon_cnt == base && n < 100) begin
      @(negedge ref_clk);
      n++;
    end
    check_eq("restart_first_tap", 32'(mon_last_val), 32'd0);
    wait_done("restart");
    check_eq("restart_n_loads", mon_cnt - base,  32'd33);
    check_eq("restart_cal_tap", 32'(cal_tap),    32'd14);
    check_eq("restart_map",     pass_map,        32'h001FFF00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9363_delay_cal.md
Name: ad9363_delay_cal

Overview:
Calibration sequencer for one IDELAY channel (RX data path or TX data path) of the AD9363 CMOS interface.
- Sweeps the 5-bit tap value from 0 to 31, pulsing the load strobe once per tap.
- After each tap load, commands an external pattern checker and records pass/fail for that tap.
- At the end of the sweep, loads the centre of the longest contiguous passing window.
- Instantiated once per channel (rx_delay_*, tx_delay_*) next to the interface wrapper, in the ref_clk domain.

Parameters:
- SETTLE_CYCLES, 16: ref_clk cycles to wait after a tap load before starting the check (1..65535).
- TIMEOUT_CYCLES, 4096: ref_clk cycles to wait for chk_done before the tap is scored as fail (1..65535).
- DEFAULT_TAP, 16: tap loaded at reset and on calibration failure.

Ports:
- ref_clk  in  1  Single clock for all logic.
- rst  in  1  Asynchronous reset, active-high.
- cal_start  in  1  One-cycle request to start a calibration; ignored while cal_busy=1.
- chk_done  in  1  Checker result-valid pulse (already synchronised to ref_clk).
- chk_pass  in  1  Checker verdict; sampled only in the cycle where chk_done=1.
- chk_start  out  1  One-cycle pulse commanding the checker to run one measurement.
- delay_value  out  5  Tap value driven to the IDELAY.
- delay_load_en  out  1  One-cycle load strobe for the IDELAY.
- cal_busy  out  1  High from the cycle after an accepted cal_start until the final load.
- cal_done  out  1  Sticky; set when calibration completes, cleared on the next accepted cal_start.
- cal_fail  out  1  Sticky; set at completion when no tap passed.
- cal_tap  out  5  Tap finally loaded.
- pass_map  out  32  Bit n = pass result for tap n.

Behaviour:
Reset values:
- delay_value=DEFAULT_TAP, cal_tap=DEFAULT_TAP.
- delay_load_en=0, chk_start=0, cal_busy=0, cal_done=0, cal_fail=0, pass_map=0.
- Reset asserted mid-sweep returns to IDLE immediately. No final load is issued.

State machine: IDLE, LOAD, SETTLE, CHECK, WAIT, NEXT, FINAL, DONE.
- IDLE: on cal_start go to LOAD.
  - Clear tap=0, pass_map, cal_done, cal_fail and the window trackers.
  - cal_busy rises on the same edge.
- LOAD: delay_value<=tap and delay_load_en=1 for exactly one cycle, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: chk_start=1 for one cycle, then go to WAIT.
- WAIT: the timeout counter runs from 0.
  - On chk_done: record pass_map[tap]=chk_pass and go to NEXT.
  - If the counter reaches TIMEOUT_CYCLES-1 with no chk_done: record fail and go to NEXT.
  - chk_done arriving in any other state is ignored.
- NEXT: update the window trackers.
  - On pass: if cur_len==0 then cur_start=tap; then cur_len+1; if cur_len > best_len then best=(cur_start,cur_len). Strictly greater, so the first of equal-length windows wins.
  - On fail: cur_len=0.
  - If tap==31 go to FINAL, else tap+1 and go to LOAD.
- FINAL: compute the result tap.
  - If best_len>0: center = best_start + ((best_len-1)>>1) (floor, 5-bit, no wrap).
  - Otherwise: center = DEFAULT_TAP and cal_fail=1.
  - delay_value<=center, one-cycle delay_load_en, cal_tap<=center, then go to DONE.
- DONE: cal_busy=0, cal_done=1; behaves as IDLE (accepts cal_start).

Other rules:
- Windows never wrap from tap 31 to tap 0.
- Minimum per-tap time is 1+SETTLE_CYCLES+1+1+1 cycles.

Optional Feature:
Macro: AD9363_DELAY_CAL_MANUAL_EN.
- When defined, adds inputs man_load (1 bit) and man_tap (5 bits).
  - In IDLE or DONE, a man_load pulse sets delay_value=cal_tap=man_tap and pulses delay_load_en on the next cycle.
  - cal_done and cal_fail are unchanged.
  - man_load is ignored while busy.
  - If man_load and cal_start arrive in the same cycle, cal_start wins.
- When undefined, these ports and that logic do not exist.

Decomposition:
- Shared package ad9363_pkg: state enum, TAP_W=5, NUM_TAPS=32.
- Optional sub-module ad9363_win_track: the best-window tracker plus centre computation. It is purely sequential per-tap, which keeps the FSM small.

Test Plan:
- Checker model passes taps 8..20 -> pass_map=32'h001FFF00, cal_tap=14, final load of 14, cal_fail=0.
- Passing windows at taps 2..5 and 10..12 -> cal_tap=3 (longest window wins).
- Two equal windows at taps 0..3 and 20..23 -> cal_tap=1 (first window wins); all 32 taps pass -> cal_tap=15.
- Checker never returns chk_done -> each tap takes TIMEOUT_CYCLES in WAIT, pass_map=0, cal_fail=1, cal_tap=16.
- Reset asserted at tap 10, then a new cal_start -> outputs return to reset values, and the sweep restarts at tap 0 with exactly 33 delay_load_en pulses in total.
- cal_start pulsed during a sweep -> ignored, and the sweep result is unchanged.
